// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush and
// an optional two-entry skid buffer that registers ready_o.
module pipe_stage_reg #(
    parameter int CTRL_W = 3,
    parameter int DATA_W = 69,
    parameter bit SKID   = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        occ_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;
    logic              skid_vld;
    logic              rdy;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = valid_i & rdy;
    assign out_fire = valid_q & ready_i;

    assign ready_o = rdy;
    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;
    assign occ_o   = {1'b0, valid_q} + {1'b0, skid_vld};

    if (SKID == 1'b0) begin : g_single

        assign rdy      = ~valid_q | ready_i;
        assign skid_vld = 1'b0;

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                valid_q <= 1'b0;
                ctrl_q  <= '0;
                data_q  <= '0;
            end else if (flush_i) begin
                valid_q <= 1'b0;
                ctrl_q  <= '0;
            end else if (in_fire) begin
                valid_q <= 1'b1;
                ctrl_q  <= ctrl_i;
                data_q  <= data_i;
            end else if (out_fire) begin
                valid_q <= 1'b0;
                ctrl_q  <= '0;
            end
        end

    end else begin : g_skid

        state_t            state;
        logic [CTRL_W-1:0] skid_ctrl;
        logic [DATA_W-1:0] skid_data;
        logic              skid_q;

        assign skid_vld = skid_q;

        // ready is a flop so the downstream stall never reaches upstream
        // through combinational logic
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                state     <= ST_EMPTY;
                valid_q   <= 1'b0;
                ctrl_q    <= '0;
                data_q    <= '0;
                skid_q    <= 1'b0;
                skid_ctrl <= '0;
                skid_data <= '0;
                rdy       <= 1'b1;
            end else if (flush_i) begin
                state     <= ST_EMPTY;
                valid_q   <= 1'b0;
                ctrl_q    <= '0;
                skid_q    <= 1'b0;
                skid_ctrl <= '0;
                rdy       <= 1'b1;
            end else begin
                case (state)
                    ST_EMPTY: begin
                        if (in_fire) begin
                            state   <= ST_ONE;
                            valid_q <= 1'b1;
                            ctrl_q  <= ctrl_i;
                            data_q  <= data_i;
                        end
                    end
                    ST_ONE: begin
                        if (in_fire && out_fire) begin
                            ctrl_q <= ctrl_i;
                            data_q <= data_i;
                        end else if (in_fire) begin
                            state     <= ST_TWO;
                            skid_q    <= 1'b1;
                            skid_ctrl <= ctrl_i;
                            skid_data <= data_i;
                            rdy       <= 1'b0;
                        end else if (out_fire) begin
                            state   <= ST_EMPTY;
                            valid_q <= 1'b0;
                            ctrl_q  <= '0;
                        end
                    end
                    ST_TWO: begin
                        if (out_fire) begin
                            state     <= ST_ONE;
                            ctrl_q    <= skid_ctrl;
                            data_q    <= skid_data;
                            skid_q    <= 1'b0;
                            skid_ctrl <= '0;
                            rdy       <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= ST_EMPTY;
                        valid_q <= 1'b0;
                        ctrl_q  <= '0;
                        skid_q  <= 1'b0;
                        rdy     <= 1'b1;
                    end
                endcase
            end
        end

    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register for the CPU datapath, replacing per-stage hand-written registers (EX/MEM and its siblings).
- Carries a control field and a data field with a valid/ready handshake, plus synchronous flush and optional skid entry.
- The skid entry registers ready_o to break the combinational stall path between stages.
- Control bits are forced to zero whenever the stage holds a bubble.

Parameters:
- CTRL_W, 3, width of control field (regwrite/memwrite/memtoreg style bits); zeroed on reset, flush and bubble.
- DATA_W, 69, width of data field (result, store data, RD, ...); held on bubble.
- SKID, 0, 0 = single register with combinational ready_o; 1 = two-entry skid buffer with registered ready_o.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- valid_i  in  1  upstream entry valid
- ready_o  out  1  stage can accept an entry this cycle
- ctrl_i  in  CTRL_W  upstream control field
- data_i  in  DATA_W  upstream data field
- flush_i  in  1  synchronous squash of all held entries (branch/exception)
- valid_o  out  1  output entry valid
- ready_i  in  1  downstream accepts; the hazard unit's stall drives this low
- ctrl_o  out  CTRL_W  output control; 0 whenever valid_o=0
- data_o  out  DATA_W  output data
- occ_o  out  2  entries held (0..1 when SKID=0, 0..2 when SKID=1)

Behaviour:
- Transfer definitions: in_fire = valid_i & ready_o; out_fire = valid_o & ready_i.
- Reset (rst_i=0, asynchronous):
  - valid_o=0, ctrl_o=0, data_o=0, occ_o=0.
  - Skid entry is invalid; ready_o=1 for SKID=0, and is 1 on the first cycle after reset release for SKID=1.
- Bubble rule: ctrl_o is ANDed with valid_o at the register; a bubble never asserts a control bit. data_o keeps its last value on a bubble.
- SKID=0:
  - ready_o = ~valid_o | ready_i (combinational).
  - On in_fire, load ctrl/data and set valid_o=1 next cycle.
  - On out_fire without in_fire, clear valid_o and ctrl_o.
  - Otherwise hold. Latency is 1 cycle; full throughput.
- SKID=1, states EMPTY(occ 0), ONE(occ 1), TWO(occ 2); ready_o = (state != TWO), registered.
  - EMPTY, in_fire -> ONE: output regs load.
  - ONE, in_fire & out_fire -> ONE: output regs load the new entry.
  - ONE, in_fire & ~out_fire -> TWO: new entry goes to skid reg.
  - ONE, out_fire & ~in_fire -> EMPTY.
  - TWO, out_fire -> ONE: skid reg moves to output regs. No in_fire is possible because ready_o=0.
  - TWO, ~out_fire -> hold.
  - Ordering is FIFO: the skid entry is always newer than the output entry.
  - Latency is 1 cycle when empty; full throughput while ready_i is high.
- Flush (flush_i=1 at a clock edge):
  - All entries are invalidated: valid_o=0, ctrl_o=0, occ_o=0, state EMPTY.
  - A simultaneous in_fire is discarded (flush wins).
  - A simultaneous out_fire still completes downstream; the stage still empties.
  - data_o may hold any value after flush; the verifier ignores data_o when valid_o=0.
- Simultaneous reset and flush: reset dominates.
- Reset asserted mid-operation: all entries are lost immediately, with no clock edge required.
- valid_i may drop without a handshake; the stage samples only on in_fire.
- ready_o must not depend on valid_i in either mode.
- occ_o = valid_o + skid_valid, always consistent with state.

Test Plan:
1. SKID=0 streaming: after reset, apply valid_i=1, ready_i=1, ctrl_i=3'b110, data_i=0x5 then 0x6 on consecutive cycles -> valid_o=1 with data_o=0x5 the cycle after the first, 0x6 the next; ctrl_o=3'b110; occ_o=1.
2. Stall hold: with 0xA held, drive ready_i=0 for 3 cycles and offer 0xB -> SKID=0: ready_o=0, data_o stays 0xA. SKID=1: 0xB goes to skid (occ_o=2, ready_o=0); on ready_i=1, data_o shows 0xA then 0xB, with no loss or duplicate.
3. Flush with simultaneous load: valid_o=1, flush_i=1 and in_fire in the same cycle -> next cycle valid_o=0, ctrl_o=0, occ_o=0; the incoming entry never appears.
4. Bubble control masking: entry with ctrl 3'b111, then valid_i=0, ready_i=1 -> valid_o=0 and ctrl_o=3'b000 in the following cycle.
5. Async reset mid-operation (SKID=1, occ_o=2): pull rst_i low between edges -> valid_o=0, ctrl_o=0, occ_o=0 immediately. After release, ready_o=1.
6. Random valid_i/ready_i/flush_i, 10k cycles, both SKID values -> scoreboard shows in-order delivery and no loss except flushed entries; ctrl_o=0 whenever valid_o=0; ready_o never depends on valid_i.
